// File: rtl/sha256_ctrl.sv
// sha256_ctrl: sequencer for the sha256_engine datapath.
// Packs a pre-padded stream of 32-bit words into 512-bit blocks, resets the
// engine at message start, issues one start per block, flags the final block
// and captures the resulting digest for the register bank.
// Optional feature: define SHA256_CTRL_PERF_EN to build the 32-bit cycle
// counter behind perf_cycles_o; without it perf_cycles_o is tied to zero.
module sha256_ctrl #(
    parameter int BLKCNT_W = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                msg_start_i,
    input  logic                abort_i,
    input  logic [31:0]         wr_data_i,
    input  logic                wr_valid_i,
    input  logic                wr_last_i,
    output logic                wr_ready_o,
    output logic                eng_rstn_o,
    output logic                eng_start_o,
    output logic                eng_fifo_empty_o,
    output logic [511:0]        eng_vec_o,
    input  logic                eng_ready_i,
    input  logic                eng_valid_i,
    input  logic [255:0]        eng_hash_i,
    output logic [255:0]        hash_o,
    output logic                hash_valid_o,
    output logic                busy_o,
    output logic                err_o,
    output logic [BLKCNT_W-1:0] blk_cnt_o,
    output logic [31:0]         perf_cycles_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERST,
        S_FILL,
        S_START,
        S_ACK,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state, state_n;
    logic                 erst_cnt, erst_cnt_n;
    logic                 to_idle, to_idle_n;
    logic [3:0]           word_idx, word_idx_n;
    logic                 last, last_n;
    logic [511:0]         vec_n;
    logic                 start_n;
    logic [BLKCNT_W-1:0]  blk_cnt_n;
    logic [255:0]         hash_n;
    logic                 hash_valid_n;
    logic                 err_n;
    logic                 accept;

    assign accept = (state == S_FILL) && wr_valid_i && wr_ready_o;

    // Next-state and next-output decisions; abort overrides everything else.
    always_comb begin
        state_n      = state;
        erst_cnt_n   = erst_cnt;
        to_idle_n    = to_idle;
        word_idx_n   = word_idx;
        last_n       = last;
        vec_n        = eng_vec_o;
        start_n      = 1'b0;
        blk_cnt_n    = blk_cnt_o;
        hash_n       = hash_o;
        hash_valid_n = hash_valid_o;
        err_n        = err_o;

        if (abort_i) begin
            hash_valid_n = 1'b0;
            if (state != S_IDLE) begin
                state_n    = S_ERST;
                erst_cnt_n = 1'b0;
                to_idle_n  = 1'b1;
                last_n     = 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (msg_start_i) begin
                        blk_cnt_n    = '0;
                        hash_valid_n = 1'b0;
                        err_n        = 1'b0;
                        last_n       = 1'b0;
                        to_idle_n    = 1'b0;
                        erst_cnt_n   = 1'b0;
                        state_n      = S_ERST;
                    end
                end
                S_ERST: begin
                    if (erst_cnt) begin
                        state_n    = to_idle ? S_IDLE : S_FILL;
                        erst_cnt_n = 1'b0;
                        word_idx_n = 4'd0;
                    end else begin
                        erst_cnt_n = 1'b1;
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        vec_n = {eng_vec_o[479:0], wr_data_i};
                        if (word_idx == 4'd15) begin
                            last_n  = wr_last_i;
                            state_n = S_START;
                        end else if (wr_last_i) begin
                            err_n      = 1'b1;
                            state_n    = S_ERST;
                            erst_cnt_n = 1'b0;
                            to_idle_n  = 1'b1;
                            word_idx_n = 4'd0;
                        end else begin
                            word_idx_n = word_idx + 4'd1;
                        end
                    end
                end
                S_START: begin
                    if (eng_ready_i) begin
                        start_n = 1'b1;
                        state_n = S_ACK;
                    end
                end
                S_ACK: begin
                    if (!eng_ready_i) begin
                        state_n = S_RUN;
                    end
                end
                S_RUN: begin
                    if (eng_ready_i) begin
                        if (blk_cnt_o != '1) begin
                            blk_cnt_n = blk_cnt_o + BLKCNT_W'(1);
                        end
                        if (last) begin
                            state_n = S_DONE;
                        end else begin
                            state_n    = S_FILL;
                            word_idx_n = 4'd0;
                        end
                    end
                end
                S_DONE: begin
                    if (eng_valid_i) begin
                        hash_n       = eng_hash_i;
                        hash_valid_n = 1'b1;
                        state_n      = S_IDLE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    // State register and internal sequencing bookkeeping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            erst_cnt <= 1'b0;
            to_idle  <= 1'b0;
            word_idx <= 4'd0;
            last     <= 1'b0;
        end else begin
            state    <= state_n;
            erst_cnt <= erst_cnt_n;
            to_idle  <= to_idle_n;
            word_idx <= word_idx_n;
            last     <= last_n;
        end
    end

    // Registered outputs, all derived from the upcoming state so they line up with it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ready_o       <= 1'b0;
            eng_rstn_o       <= 1'b0;
            eng_start_o      <= 1'b0;
            eng_fifo_empty_o <= 1'b0;
            eng_vec_o        <= '0;
            hash_o           <= '0;
            hash_valid_o     <= 1'b0;
            busy_o           <= 1'b0;
            err_o            <= 1'b0;
            blk_cnt_o        <= '0;
        end else begin
            wr_ready_o       <= (state_n == S_FILL);
            eng_rstn_o       <= (state_n != S_ERST);
            eng_start_o      <= start_n;
            eng_fifo_empty_o <= last_n && (state_n inside {S_START, S_ACK, S_RUN});
            eng_vec_o        <= vec_n;
            hash_o           <= hash_n;
            hash_valid_o     <= hash_valid_n;
            busy_o           <= (state_n != S_IDLE);
            err_o            <= err_n;
            blk_cnt_o        <= blk_cnt_n;
        end
    end

`ifdef SHA256_CTRL_PERF_EN
    logic [31:0] perf_cnt;
    logic        perf_clr;
    logic        perf_cap;

    assign perf_clr = (state == S_IDLE) && msg_start_i && !abort_i;
    assign perf_cap = (state == S_DONE) && eng_valid_i && !abort_i;

    // Busy-cycle counter: cleared at message start, saturating, frozen once the digest lands.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cnt <= '0;
        end else if (perf_clr) begin
            perf_cnt <= '0;
        end else if ((state != S_IDLE) && !perf_cap && (perf_cnt != 32'hFFFF_FFFF)) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_cycles_o = perf_cnt;
`else
    assign perf_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_sha256_ctrl.sv
// tb_sha256_ctrl: self-checking bench for sha256_ctrl with a behavioural
// SHA-256 engine model and a message-level reference digest.
module tb_sha256_ctrl;

    localparam int BW = 16;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [255:0] ABC_HASH   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_HASH = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_HASH   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          msg_start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_last = 1'b0;
    logic          wr_ready_o;
    logic          eng_rstn_o;
    logic          eng_start_o;
    logic          eng_fifo_empty_o;
    logic [511:0]  eng_vec_o;
    logic          eng_ready = 1'b0;
    logic          eng_valid = 1'b0;
    logic [255:0]  eng_hash = '0;
    logic [255:0]  hash_o;
    logic          hash_valid_o;
    logic          busy_o;
    logic          err_o;
    logic [BW-1:0] blk_cnt_o;
    logic [31:0]   perf_cycles_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] msg_words[$];
    bit          inject_busy_start = 1'b0;
    int          last_span = 0;

    sha256_ctrl #(.BLKCNT_W(BW)) dut (
        .clk(clk), .rstn(rstn), .msg_start_i(msg_start), .abort_i(abort),
        .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_last_i(wr_last), .wr_ready_o(wr_ready_o),
        .eng_rstn_o(eng_rstn_o), .eng_start_o(eng_start_o), .eng_fifo_empty_o(eng_fifo_empty_o),
        .eng_vec_o(eng_vec_o), .eng_ready_i(eng_ready), .eng_valid_i(eng_valid), .eng_hash_i(eng_hash),
        .hash_o(hash_o), .hash_valid_o(hash_valid_o), .busy_o(busy_o), .err_o(err_o),
        .blk_cnt_o(blk_cnt_o), .perf_cycles_o(perf_cycles_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    function automatic logic [511:0] block_of(input int bi);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[511 - 32*i -: 32] = msg_words[16*bi + i];
        return v;
    endfunction

    function automatic logic [255:0] ref_digest(input int nblk);
        logic [255:0] hv;
        hv = IV;
        for (int bi = 0; bi < nblk; bi++) hv = sha_compress(hv, block_of(bi));
        return hv;
    endfunction

    // Engine model: synchronous reset reloads IV, start drops ready, random latency.
    logic [255:0] eng_h = IV;
    logic [511:0] eng_blk = '0;
    logic         eng_last = 1'b0;
    logic         eng_busy = 1'b0;
    int           eng_cnt = 0;

    always @(posedge clk) begin
        if (!eng_rstn_o) begin
            eng_h     <= IV;
            eng_ready <= 1'b1;
            eng_valid <= 1'b0;
            eng_busy  <= 1'b0;
            eng_cnt   <= 0;
        end else if (eng_busy) begin
            if (eng_cnt == 0) begin
                eng_h     <= sha_compress(eng_h, eng_blk);
                eng_ready <= 1'b1;
                eng_busy  <= 1'b0;
                if (eng_last) begin
                    eng_valid <= 1'b1;
                    eng_hash  <= sha_compress(eng_h, eng_blk);
                end
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end else if (eng_start_o && eng_ready) begin
            eng_blk   <= eng_vec_o;
            eng_last  <= eng_fifo_empty_o;
            eng_busy  <= 1'b1;
            eng_ready <= 1'b0;
            eng_valid <= 1'b0;
            eng_cnt   <= int'($urandom_range(3, 8));
        end
    end

    // Monitor: logs each start (with its block and final flag) and engine-reset cycles.
    int           start_cnt = 0;
    int           rlow_cnt = 0;
    logic         fe_q[$];
    logic [511:0] vec_q[$];

    always @(posedge clk) begin
        if (rstn) begin
            if (eng_start_o) begin
                start_cnt <= start_cnt + 1;
                fe_q.push_back(eng_fifo_empty_o);
                vec_q.push_back(eng_vec_o);
            end
            if (!eng_rstn_o) rlow_cnt <= rlow_cnt + 1;
        end
    end

    task automatic pulse_start();
        @(negedge clk) msg_start = 1'b1;
        @(negedge clk) msg_start = 1'b0;
    endtask

    task automatic feed(input int first, input int n, input int last_at, input int gap_pct,
                        output bit timeout);
        int i = 0;
        int cyc = 0;
        int first_acc = -1;
        last_span = 0;
        while (i < n && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            msg_start = inject_busy_start && (cyc == 8);
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                wr_valid = 1'b0;
                wr_last  = 1'b0;
            end else begin
                wr_valid = 1'b1;
                wr_data  = msg_words[first + i];
                wr_last  = (i == last_at);
                if (wr_ready_o) begin
                    if (first_acc < 0) first_acc = cyc;
                    last_span = cyc - first_acc + 1;
                    i++;
                end
            end
        end
        timeout = (i < n);
        @(negedge clk);
        wr_valid  = 1'b0;
        wr_last   = 1'b0;
        wr_data   = '0;
        msg_start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit timeout);
        int c = 0;
        @(negedge clk);
        while (busy_o && c < limit) begin
            @(negedge clk);
            c++;
        end
        timeout = busy_o;
    endtask

    task automatic wait_start(input int limit, output bit timeout);
        int c = 0;
        while (!eng_start_o && c < limit) begin
            @(negedge clk);
            c++;
        end
        timeout = !eng_start_o;
    endtask

    task automatic run_message(input int nblk, input int gap_pct, output bit timeout);
        bit t1, t2;
        pulse_start();
        feed(0, 16*nblk, 16*nblk - 1, gap_pct, t1);
        wait_idle(3000, t2);
        timeout = t1 | t2;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (eng_rstn_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_eng_rstn_in_reset got %b exp 0", eng_rstn_o); end
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        checks++; if (eng_rstn_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_eng_rstn got %b exp 1", eng_rstn_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %b exp 0", busy_o); end
        checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr_ready got %b exp 0", wr_ready_o); end
        checks++; if (eng_start_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_eng_start got %b exp 0", eng_start_o); end
        checks++; if (eng_fifo_empty_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_fifo_empty got %b exp 0", eng_fifo_empty_o); end
        checks++; if (eng_vec_o !== '0) begin errors++; $display("[TB] FAIL rst_vec got %h exp 0", eng_vec_o); end
        checks++; if (hash_o !== '0) begin errors++; $display("[TB] FAIL rst_hash got %h exp 0", hash_o); end
        checks++; if (hash_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_hash_valid got %b exp 0", hash_valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_err got %b exp 0", err_o); end
        checks++; if (blk_cnt_o !== '0) begin errors++; $display("[TB] FAIL rst_blk_cnt got %0d exp 0", blk_cnt_o); end
        checks++; if (perf_cycles_o !== '0) begin errors++; $display("[TB] FAIL rst_perf got %0d exp 0", perf_cycles_o); end
    endtask

    task automatic test_abc();
        bit to;
        int s0, r0;
        logic [31:0] pc;
        msg_words.delete();
        msg_words.push_back(32'h61626380);
        for (int i = 1; i < 15; i++) msg_words.push_back(32'h0);
        msg_words.push_back(32'h00000018);
        s0 = start_cnt; r0 = rlow_cnt;
        run_message(1, 0, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL abc_timeout got %b exp 0", to); end
        checks++; if (hash_o !== ABC_HASH) begin errors++; $display("[TB] FAIL abc_hash got %h exp %h", hash_o, ABC_HASH); end
        checks++; if (hash_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL abc_hash_valid got %b exp 1", hash_valid_o); end
        checks++; if (blk_cnt_o !== BW'(1)) begin errors++; $display("[TB] FAIL abc_blk_cnt got %0d exp 1", blk_cnt_o); end
        checks++; if (start_cnt - s0 !== 1) begin errors++; $display("[TB] FAIL abc_starts got %0d exp 1", start_cnt - s0); end
        checks++; if (fe_q[$] !== 1'b1) begin errors++; $display("[TB] FAIL abc_fifo_empty got %b exp 1", fe_q[$]); end
        checks++; if (vec_q[$] !== block_of(0)) begin errors++; $display("[TB] FAIL abc_vec got %h exp %h", vec_q[$], block_of(0)); end
        checks++; if (rlow_cnt - r0 !== 2) begin errors++; $display("[TB] FAIL abc_eng_rst_cycles got %0d exp 2", rlow_cnt - r0); end
        checks++; if (last_span !== 16) begin errors++; $display("[TB] FAIL abc_fill_cycles got %0d exp 16", last_span); end
        pc = perf_cycles_o;
        repeat (5) @(negedge clk);
`ifdef SHA256_CTRL_PERF_EN
        checks++; if (pc === 32'd0) begin errors++; $display("[TB] FAIL abc_perf_nonzero got %0d exp >0", pc); end
        checks++; if (perf_cycles_o !== pc) begin errors++; $display("[TB] FAIL abc_perf_stable got %0d exp %0d", perf_cycles_o, pc); end
`else
        checks++; if (perf_cycles_o !== 32'd0) begin errors++; $display("[TB] FAIL abc_perf_tied got %0d exp 0", perf_cycles_o); end
`endif
    endtask

    task automatic test_empty();
        bit to;
        msg_words.delete();
        msg_words.push_back(32'h80000000);
        for (int i = 1; i < 16; i++) msg_words.push_back(32'h0);
        run_message(1, 30, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL empty_timeout got %b exp 0", to); end
        checks++; if (hash_o !== EMPTY_HASH) begin errors++; $display("[TB] FAIL empty_hash got %h exp %h", hash_o, EMPTY_HASH); end
    endtask

    task automatic test_two_block();
        bit to;
        int s0, r0;
        logic [31:0] words [32] = '{
            32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000001c0};
        msg_words.delete();
        for (int i = 0; i < 32; i++) msg_words.push_back(words[i]);
        s0 = start_cnt; r0 = rlow_cnt;
        run_message(2, 20, to);
        checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL two_timeout got %b exp 0", to); end
        checks++; if (hash_o !== TWO_HASH) begin errors++; $display("[TB] FAIL two_hash got %h exp %h", hash_o, TWO_HASH); end
        checks++; if (blk_cnt_o !== BW'(2)) begin errors++; $display("[TB] FAIL two_blk_cnt got %0d exp 2", blk_cnt_o); end
        checks++; if (start_cnt - s0 !== 2) begin errors++; $display("[TB] FAIL two_starts got %0d exp 2", start_cnt - s0); end
        if (start_cnt - s0 == 2) begin
            checks++; if (fe_q[$-1] !== 1'b0) begin errors++; $display("[TB] FAIL two_fe_blk1 got %b exp 0", fe_q[$-1]); end
            checks++; if (fe_q[$] !== 1'b1) begin errors++; $display("[TB] FAIL two_fe_blk2 got %b exp 1", fe_q[$]); end
        end
        checks++; if (rlow_cnt - r0 !== 2) begin errors++; $display("[TB] FAIL two_eng_rst_cycles got %0d exp 2", rlow_cnt - r0); end
    endtask

    task automatic test_framing();
        bit t1, t2;
        int s0, r0;
        msg_words.delete();
        for (int i = 0; i < 16; i++) msg_words.push_back($urandom());
        s0 = start_cnt; r0 = rlow_cnt;
        pulse_start();
        feed(0, 6, 5, 0, t1);
        wait_idle(200, t2);
        checks++; if ((t1 | t2) !== 1'b0) begin errors++; $display("[TB] FAIL frame_timeout got %b exp 0", t1 | t2); end
        checks++; if (err_o !== 1'b1) begin errors++; $display("[TB] FAIL frame_err got %b exp 1", err_o); end
        checks++; if (hash_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL frame_hash_valid got %b exp 0", hash_valid_o); end
        checks++; if (start_cnt - s0 !== 0) begin errors++; $display("[TB] FAIL frame_starts got %0d exp 0", start_cnt - s0); end
        checks++; if (rlow_cnt - r0 !== 4) begin errors++; $display("[TB] FAIL frame_eng_rst_cycles got %0d exp 4", rlow_cnt - r0); end
        checks++; if (wr_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL frame_wr_ready got %b exp 0", wr_ready_o); end
    endtask

    task automatic test_abort();
        bit t1, t2, t3;
        int r0;
        msg_words.delete();
        for (int i = 0; i < 32; i++) msg_words.push_back($urandom());
        r0 = rlow_cnt;
        pulse_start();
        feed(0, 16, -1, 0, t1);
        wait_start(100, t2);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        wait_idle(100, t3);
        checks++; if ((t1 | t2 | t3) !== 1'b0) begin errors++; $display("[TB] FAIL abort_timeout got %b exp 0", t1 | t2 | t3); end
        checks++; if (hash_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_hash_valid got %b exp 0", hash_valid_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL abort_err got %b exp 0", err_o); end
        checks++; if (blk_cnt_o !== '0) begin errors++; $display("[TB] FAIL abort_blk_cnt got %0d exp 0", blk_cnt_o); end
        checks++; if (rlow_cnt - r0 !== 4) begin errors++; $display("[TB] FAIL abort_eng_rst_cycles got %0d exp 4", rlow_cnt - r0); end
        msg_words.delete();
        msg_words.push_back(32'h61626380);
        for (int i = 1; i < 15; i++) msg_words.push_back(32'h0);
        msg_words.push_back(32'h00000018);
        run_message(1, 10, t1);
        checks++; if (t1 !== 1'b0) begin errors++; $display("[TB] FAIL abort_abc_timeout got %b exp 0", t1); end
        checks++; if (hash_o !== ABC_HASH) begin errors++; $display("[TB] FAIL abort_abc_hash got %h exp %h", hash_o, ABC_HASH); end
    endtask

    task automatic test_random();
        bit to;
        int nblk, s0, q0;
        logic [255:0] exp_h;
        for (int it = 0; it < 4; it++) begin
            nblk = int'($urandom_range(1, 3));
            msg_words.delete();
            for (int i = 0; i < 16*nblk; i++) msg_words.push_back($urandom());
            exp_h = ref_digest(nblk);
            s0 = start_cnt; q0 = fe_q.size();
            inject_busy_start = (it == 1);
            run_message(nblk, 25, to);
            inject_busy_start = 1'b0;
            checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_timeout got %b exp 0", it, to); end
            checks++; if (hash_o !== exp_h) begin errors++; $display("[TB] FAIL rand%0d_hash got %h exp %h", it, hash_o, exp_h); end
            checks++; if (blk_cnt_o !== BW'(nblk)) begin errors++; $display("[TB] FAIL rand%0d_blk_cnt got %0d exp %0d", it, blk_cnt_o, nblk); end
            checks++; if (start_cnt - s0 !== nblk) begin errors++; $display("[TB] FAIL rand%0d_starts got %0d exp %0d", it, start_cnt - s0, nblk); end
            if (fe_q.size() - q0 == nblk) begin
                for (int bi = 0; bi < nblk; bi++) begin
                    checks++; if (fe_q[q0+bi] !== (bi == nblk - 1)) begin errors++; $display("[TB] FAIL rand%0d_fe%0d got %b exp %b", it, bi, fe_q[q0+bi], bi == nblk - 1); end
                    checks++; if (vec_q[q0+bi] !== block_of(bi)) begin errors++; $display("[TB] FAIL rand%0d_vec%0d got %h exp %h", it, bi, vec_q[q0+bi], block_of(bi)); end
                end
            end
        end
    endtask

    task automatic test_rstn_mid_run();
        bit t1, t2;
        msg_words.delete();
        for (int i = 0; i < 16; i++) msg_words.push_back($urandom());
        pulse_start();
        feed(0, 16, 15, 0, t1);
        wait_start(100, t2);
        checks++; if ((t1 | t2) !== 1'b0) begin errors++; $display("[TB] FAIL mid_timeout got %b exp 0", t1 | t2); end
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++; if (eng_rstn_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_eng_rstn got %b exp 0", eng_rstn_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got %b exp 0", busy_o); end
        checks++; if (hash_o !== '0) begin errors++; $display("[TB] FAIL mid_hash got %h exp 0", hash_o); end
        checks++; if (eng_vec_o !== '0) begin errors++; $display("[TB] FAIL mid_vec got %h exp 0", eng_vec_o); end
        checks++; if (eng_fifo_empty_o !== 1'b0) begin errors++; $display("[TB] FAIL mid_fifo_empty got %b exp 0", eng_fifo_empty_o); end
        checks++; if (perf_cycles_o !== '0) begin errors++; $display("[TB] FAIL mid_perf got %0d exp 0", perf_cycles_o); end
        @(negedge clk) rstn = 1'b1;
        @(negedge clk);
        checks++; if (eng_rstn_o !== 1'b1) begin errors++; $display("[TB] FAIL mid_eng_rstn_release got %b exp 1", eng_rstn_o); end
    endtask

    // Global guard so a stalled DUT can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_framing();
        test_abort();
        test_random();
        test_rstn_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_ctrl.md
# sha256_ctrl

Sequencer for the `sha256_engine` datapath. It accepts a pre-padded message as a stream of 32-bit words and packs each 16 words into a 512-bit block. It re-initialises the engine at message start, issues one start per block and flags the final block. It captures the 256-bit digest and exposes it to the register bank with status and block count.

## Interface
- `BLKCNT_W`, default 16: width of the processed-block counter.
- `clk`  in  1: system clock.
- `rstn`  in  1: asynchronous, active-low reset.
- `msg_start_i`  in  1: one-cycle pulse that opens a new message. Ignored unless in IDLE.
- `abort_i`  in  1: one-cycle pulse that cancels the current message from any state.
- `wr_data_i`  in  32: message word, big-endian; the first word is W0.
- `wr_valid_i`  in  1: word qualifier.
- `wr_last_i`  in  1: marks the final word of the message.
- `wr_ready_o`  out  1: controller accepts a word when `wr_valid_i && wr_ready_o`.
- `eng_rstn_o`  out  1: engine reset, registered, active-low.
- `eng_start_o`  out  1: engine start, one-cycle pulse.
- `eng_fifo_empty_o`  out  1: high while the final block is in flight.
- `eng_vec_o`  out  512: block; W0 at [511:480].
- `eng_ready_i`  in  1: engine ready.
- `eng_valid_i`  in  1: engine digest valid.
- `eng_hash_i`  in  256: engine digest.
- `hash_o`  out  256: captured digest.
- `hash_valid_o`  out  1: digest valid; cleared by `msg_start_i` or `abort_i`.
- `busy_o`  out  1: high in every state except IDLE.
- `err_o`  out  1: sticky framing error; cleared by `msg_start_i`.
- `blk_cnt_o`  out  BLKCNT_W: blocks completed in the current message.
- `perf_cycles_o`  out  32: cycles from `msg_start_i` to digest capture.

## Operation
States: IDLE, ERST, FILL, START, ACK, RUN, DONE.
- **IDLE**
  - `wr_ready_o=0`.
  - On `msg_start_i`: clear `blk_cnt_o`, `hash_valid_o` and `err_o`; go to ERST.
- **ERST**
  - Hold `eng_rstn_o=0` for exactly 2 cycles. The engine reset is synchronous, and this reloads its initial hash values.
  - Then go to FILL with word index 0.
- **FILL**
  - `wr_ready_o=1`. Each accepted word is shifted into the 16×32 block buffer and the index increments.
  - On the 16th word: go to START. `wr_last_i` on that word sets the internal `last` flag.
  - `wr_last_i` on words 0..14 is a framing error: set `err_o`, drop the partial block, go to ERST then IDLE.
- **START**
  - Wait for `eng_ready_i=1`, then pulse `eng_start_o` for one cycle and go to ACK.
- **ACK**
  - Wait for `eng_ready_i=0`, which is the engine's acknowledge, then go to RUN.
- **RUN**
  - On `eng_ready_i=1`: increment `blk_cnt_o` (saturating at all-ones).
  - If `last`: go to DONE. Otherwise: go to FILL with index 0.
- **DONE**
  - Wait for `eng_valid_i=1`, latch `eng_hash_i` into `hash_o`, set `hash_valid_o=1`, go to IDLE.
- **Abort**
  - `abort_i` in any non-IDLE state goes to ERST with `last` cleared, then IDLE.
  - `hash_valid_o` is cleared and `err_o` is unchanged.
  - If `msg_start_i` and `abort_i` are asserted together, abort wins.
- **Engine-side outputs**
  - `eng_vec_o` is the block buffer. It is frozen from START until RUN exits; `wr_ready_o=0` during START, ACK, RUN and DONE.
  - `eng_fifo_empty_o = last` in START, ACK and RUN; 0 elsewhere.

## Timing
- Reset values of all outputs:
  - `eng_rstn_o=0` during reset, then 1 from the first clock after release.
  - All other outputs are 0, including `hash_o` and the counters.
- All outputs are registered. Inputs are sampled on the rising edge of `clk`.
- Controller overhead per block: START→ACK 2 cycles plus 1 RUN-exit cycle. The engine's own latency is added on top.
- Digest capture is 1 cycle after engine ready rises on the final block.
- `wr_ready_o` rises in the cycle after the RUN→FILL transition.
- Back-to-back `wr_valid_i` fills a block in 16 cycles.
- `msg_start_i` while busy is ignored and has no side effects.

## Configuration
- With `SHA256_CTRL_PERF_EN` defined:
  - A 32-bit cycle counter is cleared on `msg_start_i` and increments every cycle while busy.
  - It saturates at 0xFFFFFFFF and is frozen at digest capture.
  - `perf_cycles_o` presents it.
- Without the macro: no counter logic; `perf_cycles_o` is tied to 0.

## Test plan
- **"abc"**: single block (0x61626380, 13 zero words, 0, 0x18) with `wr_last_i` on word 15 → `hash_o` = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, `blk_cnt_o=1`, `hash_valid_o=1`.
- **Empty message**: block 0x80000000 followed by 15 zero words → e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- **Two blocks**: padded "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" → 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, `blk_cnt_o=2`.
  - `eng_fifo_empty_o` is 0 for block 1 and 1 for block 2.
  - `eng_rstn_o` is low only before block 1.
- **Framing error**: `wr_last_i` on word 5 → `err_o=1`, `eng_rstn_o` low for 2 cycles, IDLE, no start issued, `hash_valid_o=0`.
- **Abort**: assert `abort_i` during RUN of block 1, then immediately run "abc" → the correct "abc" digest. This proves the engine was re-initialised.
- **`rstn` mid-RUN**: all outputs return to their reset values asynchronously.
  - With `SHA256_CTRL_PERF_EN`: `perf_cycles_o` is nonzero after "abc" and stable until the next `msg_start_i`.
